dsp_mix_scheduler: RTL and testbench

//   Per-sample scheduler for the instrument DSP chain. On each sample tick it runs
//   N_INST instrument blocks one after another. It time-shares the single

---
 rtl/dsp_pkg.sv | 18 +
 rtl/dsp_saturate.sv | 20 ++
 rtl/dsp_mix_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_dsp_mix_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared widths and the scheduler state type for the instrument DSP chain.
package dsp_pkg;
  localparam int WAVE_W    = 24;
  localparam int MULT_W    = 32;
  localparam int DIV_W     = 48;
  localparam int GAIN_W    = 16;
  localparam int PROD_W    = 2 * MULT_W;
  // Q1.15 gain: the product is shifted right by 15 and keeps one extra bit of headroom
  localparam int GAIN_FRAC = 15;
  localparam int CONTRIB_W = WAVE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAIN,
    S_DONE
  } sched_state_t;
endpackage

// File: rtl/dsp_saturate.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits.
// Ports:
//   din_i  - signed input, IN_W bits (IN_W >= OUT_W)
//   dout_o - din_i clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module dsp_saturate #(
  parameter int IN_W  = 27,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);
  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout_o = din_i[OUT_W-1:0];
    if (din_i > MAXV)      dout_o = MAXV[OUT_W-1:0];
    else if (din_i < MINV) dout_o = MINV[OUT_W-1:0];
  end
endmodule

// File: rtl/dsp_mix_scheduler.sv
// Per-sample scheduler: on each sample tick runs the instrument slots in turn,
// time-sharing one multiplier and one divider, applies a Q1.15 gain per slot on
// the same multiplier, and emits one saturated 24-bit mix sample per frame.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   sample_tick_i        frame start pulse
//   gain_i               per-slot unsigned Q1.15 gain
//   inst_start_o         level start to the running slot (one-hot or zero)
//   inst_finish_i        per-slot done, wave valid in the same cycle
//   inst_wave_i          per-slot wave output
//   inst_mult_a/b_i      per-slot multiplier operands
//   inst_div_n/d_i       per-slot divider operands
//   mult_a/b_o, mult_p_i shared multiplier operands and product
//   div_n/d_o            shared divider operands
//   mix_out_o, mix_valid_o  mix sample and its update pulse
//   busy_o               frame in progress (through the mix_valid cycle)
//   overrun_o            dropped-tick pulse
//   timeout_err_o, timeout_slot_o  watchdog skip pulse and last skipped slot
module dsp_mix_scheduler
  import dsp_pkg::*;
#(
  parameter int N_INST      = 4,
  parameter int MULT_LAT    = 1,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = (N_INST > 1) ? $clog2(N_INST) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sample_tick_i,
  input  logic [N_INST-1:0][GAIN_W-1:0]  gain_i,
  output logic [N_INST-1:0]              inst_start_o,
  input  logic [N_INST-1:0]              inst_finish_i,
  input  logic [N_INST-1:0][WAVE_W-1:0]  inst_wave_i,
  input  logic [N_INST-1:0][MULT_W-1:0]  inst_mult_a_i,
  input  logic [N_INST-1:0][MULT_W-1:0]  inst_mult_b_i,
  input  logic [N_INST-1:0][DIV_W-1:0]   inst_div_n_i,
  input  logic [N_INST-1:0][DIV_W-1:0]   inst_div_d_i,
  output logic [MULT_W-1:0]              mult_a_o,
  output logic [MULT_W-1:0]              mult_b_o,
  input  logic [PROD_W-1:0]              mult_p_i,
  output logic [DIV_W-1:0]               div_n_o,
  output logic [DIV_W-1:0]               div_d_o,
  output logic [WAVE_W-1:0]              mix_out_o,
  output logic                           mix_valid_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  output logic                           timeout_err_o,
  output logic [IDX_W-1:0]               timeout_slot_o
);
  localparam int ACC_W = CONTRIB_W + $clog2(N_INST);
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LAT_W = $clog2(MULT_LAT + 2);

  sched_state_t                   state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [N_INST-1:0][GAIN_W-1:0]  gain_q, gain_d;
  logic [WAVE_W-1:0]              wave_q, wave_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [LAT_W-1:0]               lat_q, lat_d;
  logic [WAVE_W-1:0]              mix_q, mix_d;
  logic                           mix_valid_q, mix_valid_d;
  logic                           overrun_q, overrun_d;
  logic                           to_err_q, to_err_d;
  logic [IDX_W-1:0]               to_slot_q, to_slot_d;

  logic                           last;
  logic signed [CONTRIB_W-1:0]    contrib;
  logic signed [WAVE_W-1:0]       sat_w;
  logic                           unused_p;

  // Q1.15 scaling: bits [39:15] of the product are the scaled wave
  assign contrib  = mult_p_i[GAIN_FRAC +: CONTRIB_W];
  assign unused_p = ^{mult_p_i[PROD_W-1:GAIN_FRAC+CONTRIB_W], mult_p_i[GAIN_FRAC-1:0]};

  dsp_saturate #(.IN_W(ACC_W), .OUT_W(WAVE_W)) u_sat (
    .din_i  (acc_q),
    .dout_o (sat_w)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    gain_d       = gain_q;
    wave_d       = wave_q;
    wd_d         = wd_q;
    lat_d        = lat_q;
    mix_d        = mix_q;
    mix_valid_d  = 1'b0;
    overrun_d    = sample_tick_i && (state_q != S_IDLE);
    to_err_d     = 1'b0;
    to_slot_d    = to_slot_q;
    inst_start_o = '0;
    mult_a_o     = '0;
    mult_b_o     = '0;
    div_n_o      = '0;
    div_d_o      = '0;
    last         = (idx_q == IDX_W'(N_INST - 1));

    unique case (state_q)
      S_IDLE: begin
        if (sample_tick_i) begin
          gain_d  = gain_i;
          acc_d   = '0;
          idx_d   = '0;
          wd_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        inst_start_o[idx_q] = 1'b1;
        mult_a_o = inst_mult_a_i[idx_q];
        mult_b_o = inst_mult_b_i[idx_q];
        div_n_o  = inst_div_n_i[idx_q];
        div_d_o  = inst_div_d_i[idx_q];
        if (inst_finish_i[idx_q]) begin
          wave_d  = inst_wave_i[idx_q];
          wd_d    = '0;
          lat_d   = '0;
          state_d = S_GAIN;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          // Hung slot: skip it with zero contribution, no gain pass
          to_err_d  = 1'b1;
          to_slot_d = idx_q;
          wd_d      = '0;
          if (last) state_d = S_DONE;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RUN;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAIN: begin
        mult_a_o = MULT_W'($signed(wave_q));
        mult_b_o = {{(MULT_W-GAIN_W){1'b0}}, gain_q[idx_q]};
        if (lat_q == LAT_W'(MULT_LAT)) begin
          acc_d = acc_q + ACC_W'(contrib);
          if (last) state_d = S_DONE;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RUN;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_DONE: begin
        mix_d       = sat_w;
        mix_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      gain_q      <= '0;
      wave_q      <= '0;
      wd_q        <= '0;
      lat_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      to_err_q    <= 1'b0;
      to_slot_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      gain_q      <= gain_d;
      wave_q      <= wave_d;
      wd_q        <= wd_d;
      lat_q       <= lat_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      to_err_q    <= to_err_d;
      to_slot_q   <= to_slot_d;
    end
  end

  assign mix_out_o      = mix_q;
  assign mix_valid_o    = mix_valid_q;
  // mix_valid is registered out of DONE, so busy covers that trailing IDLE cycle too
  assign busy_o         = (state_q != S_IDLE) || mix_valid_q;
  assign overrun_o      = overrun_q;
  assign timeout_err_o  = to_err_q;
  assign timeout_slot_o = to_slot_q;
endmodule

// File: tb/tb_dsp_mix_scheduler.sv
module tb_dsp_mix_scheduler;
  import dsp_pkg::*;
  localparam int N  = 4;
  localparam int TO = 64;

  typedef struct packed {
    logic [N-1:0][15:0] g;
    logic [N-1:0][23:0] w;
    logic [N-1:0][7:0]  lat;      // cycles from start rise to finish; FF = never
    logic [N-1:0]       sp;       // finish held high permanently on these slots
    logic [23:0]        exp_mix;
    int                 to_slot;  // -1 = no timeout expected
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]                rst, tick;
  logic [N-1:0][15:0]        gain;
  logic [N-1:0][23:0]        wave;
  logic [N-1:0][31:0]        ima, imb;
  logic [N-1:0][47:0]        idn, idd;
  logic [N-1:0][7:0]         lat_cfg;
  logic [N-1:0]              spur;
  logic [1:0][N-1:0]         start, finish;
  logic [1:0][31:0]          ma, mb;
  logic [1:0][47:0]          dn, dd;
  logic [1:0][23:0]          mix;
  logic [1:0]                mv, busy, ovr, toe;
  logic [1:0][1:0]           tos;
  logic [63:0]               p0, q1, q2, q3;
  int                        cnt [2][N];

  // Instrument models: finish lat cycles after start rises, or never
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < N; s++)
        cnt[d][s] <= start[d][s] ? cnt[d][s] + 1 : 0;

  always_comb begin
    finish = '0;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < N; s++)
        finish[d][s] = spur[s] | (start[d][s] && (lat_cfg[s] != 8'hFF) &&
                                  (cnt[d][s] == int'(lat_cfg[s])));
  end

  // Shared multipliers: 1-cycle for u0, 3-cycle pipeline for u1
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b));
    return r;
  endfunction

  always @(posedge clk) begin
    p0 <= prod(ma[0], mb[0]);
    q1 <= prod(ma[1], mb[1]);
    q2 <= q1;
    q3 <= q2;
  end

  dsp_mix_scheduler #(.N_INST(N), .MULT_LAT(1), .TIMEOUT_CYC(TO)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .sample_tick_i(tick[0]), .gain_i(gain),
    .inst_start_o(start[0]), .inst_finish_i(finish[0]), .inst_wave_i(wave),
    .inst_mult_a_i(ima), .inst_mult_b_i(imb), .inst_div_n_i(idn), .inst_div_d_i(idd),
    .mult_a_o(ma[0]), .mult_b_o(mb[0]), .mult_p_i(p0), .div_n_o(dn[0]), .div_d_o(dd[0]),
    .mix_out_o(mix[0]), .mix_valid_o(mv[0]), .busy_o(busy[0]), .overrun_o(ovr[0]),
    .timeout_err_o(toe[0]), .timeout_slot_o(tos[0]));

  dsp_mix_scheduler #(.N_INST(N), .MULT_LAT(3), .TIMEOUT_CYC(TO)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .sample_tick_i(tick[1]), .gain_i(gain),
    .inst_start_o(start[1]), .inst_finish_i(finish[1]), .inst_wave_i(wave),
    .inst_mult_a_i(ima), .inst_mult_b_i(imb), .inst_div_n_i(idn), .inst_div_d_i(idd),
    .mult_a_o(ma[1]), .mult_b_o(mb[1]), .mult_p_i(q3), .div_n_o(dn[1]), .div_d_o(dd[1]),
    .mix_out_o(mix[1]), .mix_valid_o(mv[1]), .busy_o(busy[1]), .overrun_o(ovr[1]),
    .timeout_err_o(toe[1]), .timeout_slot_o(tos[1]));

  int checks = 0;
  int errors = 0;
  int exp_tos [2];
  vec_t vecs [7];

  int          obs_hi [N];
  int          obs_ord [$];
  int          obs_mv, obs_to, obs_ov;
  logic [N-1:0] obs_prev;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ml(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic vec_t mk(input logic [15:0] g0, g1, g2, g3,
                              input logic [23:0] w0, w1, w2, w3,
                              input logic [7:0] l0, l1, l2, l3,
                              input logic [3:0] sp, input logic [23:0] em, input int ts);
    vec_t v;
    v.g = {g3, g2, g1, g0};
    v.w = {w3, w2, w1, w0};
    v.lat = {l3, l2, l1, l0};
    v.sp = sp;
    v.exp_mix = em;
    v.to_slot = ts;
    return v;
  endfunction

  task automatic obs_clear();
    for (int s = 0; s < N; s++) obs_hi[s] = 0;
    obs_ord.delete();
    obs_mv = 0; obs_to = 0; obs_ov = 0; obs_prev = '0;
  endtask

  // Per-cycle monitor of one DUT, called at the negedge
  task automatic observe(input int d);
    logic [N-1:0] st;
    st = start[d];
    chk("start_onehot", 128'($countones(st) <= 1), 128'(1));
    for (int s = 0; s < N; s++) begin
      if (st[s]) begin
        obs_hi[s]++;
        if (!obs_prev[s]) obs_ord.push_back(s);
        chk("run_mult_ops", {ma[d], mb[d]}, {ima[s], imb[s]});
        chk("run_div_ops", {dn[d], dd[d]}, {idn[s], idd[s]});
      end
    end
    if (st == '0) begin
      chk("div_ops_zero", {dn[d], dd[d]}, 128'(0));
      if (!busy[d]) chk("idle_mult_zero", {ma[d], mb[d]}, 128'(0));
      else          chk("gain_b_high_zero", 128'(mb[d][31:16]), 128'(0));
    end
    obs_mv += int'(mv[d]);
    obs_to += int'(toe[d]);
    obs_ov += int'(ovr[d]);
    obs_prev = st;
  endtask

  task automatic load(input vec_t v);
    gain = v.g; wave = v.w; lat_cfg = v.lat; spur = v.sp;
  endtask

  task automatic check_reset(input int d);
    chk("rst_start", 128'(start[d]), 128'(0));
    chk("rst_ops", {ma[d], mb[d], dn[d][31:0]}, 128'(0));
    chk("rst_div_d", 128'({dn[d], dd[d]}), 128'(0));
    chk("rst_mix", 128'({mix[d], mv[d], busy[d]}), 128'(0));
    chk("rst_flags", 128'({ovr[d], toe[d], tos[d]}), 128'(0));
  endtask

  task automatic run_frame(input int d, input vec_t v);
    int n, exp_lat, hi_exp, ordv;
    bit seen, never;
    load(v);
    obs_clear();
    @(negedge clk); tick[d] = 1'b1;
    @(negedge clk); tick[d] = 1'b0;
    chk("busy_after_tick", 128'(busy[d]), 128'(1));
    n = 1; seen = 0;
    while (!seen && n <= 3000) begin
      observe(d);
      if (mv[d]) seen = 1;
      else begin @(negedge clk); n++; end
    end
    chk("frame_done", 128'(seen), 128'(1));
    exp_lat = 2;
    for (int s = 0; s < N; s++) begin
      never  = (v.lat[s] == 8'hFF) && !v.sp[s];
      hi_exp = v.sp[s] ? 1 : (never ? TO : int'(v.lat[s]) + 1);
      chk("start_cycles", 128'(obs_hi[s]), 128'(hi_exp));
      exp_lat += hi_exp + (never ? 0 : ml(d) + 1);
    end
    chk("frame_latency", 128'(n), 128'(exp_lat));
    chk("mix_out", 128'(mix[d]), 128'(v.exp_mix));
    chk("busy_in_valid_cycle", 128'(busy[d]), 128'(1));
    ordv = 0;
    foreach (obs_ord[i]) ordv = (ordv << 4) | obs_ord[i];
    chk("start_order", 128'({obs_ord.size(), ordv}), 128'({32'd4, 32'h0123}));
    if (v.to_slot >= 0) exp_tos[d] = v.to_slot;
    @(negedge clk); observe(d);
    chk("mix_valid_count", 128'(obs_mv), 128'(1));
    chk("busy_after_frame", 128'(busy[d]), 128'(0));
    chk("mix_held", 128'(mix[d]), 128'(v.exp_mix));
    chk("timeout_count", 128'(obs_to), 128'(v.to_slot >= 0));
    chk("timeout_slot", 128'(tos[d]), 128'(exp_tos[d]));
    chk("no_overrun", 128'(obs_ov), 128'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst = 2'b11; tick = 2'b00; spur = '0; gain = '0; wave = '0; lat_cfg = '0;
    exp_tos[0] = 0; exp_tos[1] = 0;
    for (int s = 0; s < N; s++) begin
      ima[s] = 32'hA000_0000 + 32'(s);
      imb[s] = 32'hB000_0000 + 32'(s * 16 + 5);
      idn[s] = 48'hC000_0000_0000 + 48'(s + 1);
      idd[s] = 48'hD000_0000_0000 + 48'(s * 3 + 2);
    end
    //          gains                               waves                                               lat                        spur    mix          timeout
    vecs[0] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 24'd100, 24'd200, -24'sd50, 24'd25,           8'd3, 8'd3, 8'd3, 8'd3,     4'b0000, 24'd275,     -1);
    vecs[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 8'd2, 8'd1, 8'd4, 8'd0,   4'b0000, 24'h7FFFFF,  -1);
    vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 8'd0, 8'd3, 8'd1, 8'd2,   4'b0000, 24'h800000,  -1);
    vecs[3] = mk(16'h4000, 16'h0000, 16'h8000, 16'h8000, 24'd1000, 24'd5000, -24'sd7, 24'd3,           8'd3, 8'd5, 8'd2, 8'd1,     4'b0000, 24'd496,     -1);
    vecs[4] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 24'd10, 24'd20, 24'd999, 24'd40,              8'd3, 8'd3, 8'hFF, 8'd2,    4'b0000, 24'd70,       2);
    vecs[5] = mk(16'h2000, 16'h4000, 16'h4000, 16'h8000, -24'sd4000, -24'sd3, 24'd7, 24'd1,            8'd1, 8'd2, 8'd0, 8'd5,     4'b1000, 24'hFFFC1A,  -1);
    vecs[6] = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000, 24'd100, 24'd200, -24'sd50, 24'd25,           8'd3, 8'd3, 8'd3, 8'd3,     4'b0000, 24'd137,     -1);

    repeat (3) @(negedge clk);
    rst = 2'b00;
    check_reset(0);
    check_reset(1);

    for (int i = 0; i < 7; i++) run_frame(0, vecs[i]);

    // Deeper multiplier pipeline must give identical mixes
    run_frame(1, vecs[3]);
    run_frame(1, vecs[5]);
    run_frame(1, vecs[0]);

    // Tick 5 cycles into a frame: overrun, and the mid-frame gain change is not seen
    load(vecs[0]);
    obs_clear();
    @(negedge clk); tick[0] = 1'b1;
    @(negedge clk); tick[0] = 1'b0;
    observe(0);
    repeat (4) begin @(negedge clk); observe(0); end
    tick[0] = 1'b1;
    gain = '0;
    @(negedge clk); tick[0] = 1'b0;
    observe(0);
    chk("overrun_pulse", 128'(ovr[0]), 128'(1));
    seen = 0; n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk); observe(0); n++;
      if (mv[0]) seen = 1;
    end
    chk("ovr_frame_done", 128'(seen), 128'(1));
    chk("ovr_frame_mix", 128'(mix[0]), 128'(275));
    repeat (60) begin @(negedge clk); observe(0); end
    chk("ovr_single_valid", 128'(obs_mv), 128'(1));
    chk("ovr_pulse_count", 128'(obs_ov), 128'(1));
    chk("ovr_no_extra_frame", 128'(obs_ord.size()), 128'(4));
    chk("ovr_idle_after", 128'(busy[0]), 128'(0));

    // Reset while slot 1 is in its gain pass
    load(vecs[0]);
    obs_clear();
    @(negedge clk); tick[0] = 1'b1;
    @(negedge clk); tick[0] = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 200) begin
      observe(0);
      if (obs_hi[1] > 0 && !start[0][1]) seen = 1;
      else begin @(negedge clk); n++; end
    end
    chk("reached_gain_slot1", 128'(seen), 128'(1));
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    check_reset(0);
    exp_tos[0] = 0;
    run_frame(0, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
